// File: rtl/calc_btn_driver.sv
// ---------------------------------------------------------------------------
// calc_btn_driver
//
// Purpose:
//   Automated operator for the calculator's button/LED pins. A host hands
//   over one {op, x, y} request. The driver replays it as press/release
//   pulses on the four button lines, waits for the LEDs to settle and
//   captures the result. It then issues a clearing confirm press so the
//   calculator is back at op entry.
//
//   The calculator is assumed to be in OP entry with all fields zero when a
//   request is accepted. No model of calculator state is kept here.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  request valid
//   o_req_ready  driver idle, request can be accepted
//   i_op/i_x/i_y request fields (3 bits each)
//   o_btn        registered button drive, 1 = pressed
//                ([3] = confirm, [2:0] = bit toggles)
//   i_led        calculator LED pins (active-low), sampled raw
//   o_rsp_valid  one-cycle pulse, o_result valid
//   o_result     ~i_led captured at the end of settling; held until the
//                next capture
// ---------------------------------------------------------------------------
module calc_btn_driver #(
    parameter int HOLD_CYCLES   = 1000000,
    parameter int GAP_CYCLES    = 1000000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [2:0] i_op,
    input  logic [2:0] i_x,
    input  logic [2:0] i_y,
    output logic [3:0] o_btn,
    input  logic [7:0] i_led,
    output logic       o_rsp_valid,
    output logic [7:0] o_result
);

    // Counter sized for the longest phase; every phase reloads it on entry,
    // so it never wraps.
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HG > SETTLE_CYCLES) ? MAX_HG : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] C_ZERO   = CW'(0);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    // Step indices: 0 op, 1 confirm, 2 x, 3 confirm, 4 y, 5 confirm, 6 clear.
    localparam logic [2:0] STEP_OP      = 3'd0;
    localparam logic [2:0] STEP_CONF0   = 3'd1;
    localparam logic [2:0] STEP_LASTARG = 3'd5;
    localparam logic [2:0] STEP_CLEAR   = 3'd6;

    // CAPTURE has an encoding but is never entered: the LED capture is
    // folded into the edge that ends SETTLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Button mask driven for a given step.
    function automatic logic [3:0] f_step_mask(input logic [2:0] step,
                                               input logic [2:0] op,
                                               input logic [2:0] x,
                                               input logic [2:0] y);
        logic [3:0] mask;
        case (step)
            3'd0:                      mask = {1'b0, op};
            3'd2:                      mask = {1'b0, x};
            3'd4:                      mask = {1'b0, y};
            3'd1, 3'd3, 3'd5, 3'd6:    mask = 4'b1000;
            default:                   mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Step that follows 'step'. An all-zero operand step is skipped. The
    // step after it is always a confirm, so at most one step is skipped.
    function automatic logic [2:0] f_next_step(input logic [2:0] step,
                                               input logic [2:0] op,
                                               input logic [2:0] x,
                                               input logic [2:0] y);
        logic [2:0] nxt;
        nxt = step + 3'd1;
        if (f_step_mask(nxt, op, x, y) == 4'b0000) begin
            nxt = nxt + 3'd1;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    state_t          r_state;
    logic [2:0]      r_step;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [2:0]      r_x;
    logic [2:0]      r_y;
    logic [3:0]      r_btn;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [7:0]      r_result;

    state_t          w_state_nxt;
    logic [2:0]      w_step_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_accept;
    logic            w_capture;
    logic [2:0]      w_op_src;
    logic [2:0]      w_x_src;
    logic [2:0]      w_y_src;
    logic [3:0]      w_btn_nxt;

    // Next-state, step, counter and button-drive decode.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            // DONE accepts too, so a waiting request starts on the
            // response cycle.
            ST_IDLE, ST_DONE: begin
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PRESS;
                    w_step_nxt  = (i_op == 3'b000) ? STEP_CONF0 : STEP_OP;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = r_step;
                    w_cnt_nxt   = C_ZERO;
                end
            end
            ST_PRESS: begin
                if (r_cnt == C_ZERO) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = C_GAP;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == C_ZERO) begin
                    if (r_step == STEP_LASTARG) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = C_SETTLE;
                    end else if (r_step == STEP_CLEAR) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = C_ZERO;
                    end else begin
                        w_state_nxt = ST_PRESS;
                        w_step_nxt  = f_next_step(r_step, r_op, r_x, r_y);
                        w_cnt_nxt   = C_HOLD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == C_ZERO) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_PRESS;
                    w_step_nxt  = STEP_CLEAR;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = 3'd0;
                w_cnt_nxt   = C_ZERO;
            end
        endcase

        // On acceptance the fields are not registered yet, so use the inputs.
        w_op_src  = w_accept ? i_op : r_op;
        w_x_src   = w_accept ? i_x  : r_x;
        w_y_src   = w_accept ? i_y  : r_y;
        w_btn_nxt = (w_state_nxt == ST_PRESS)
                    ? f_step_mask(w_step_nxt, w_op_src, w_x_src, w_y_src)
                    : 4'b0000;
    end

    // State, step and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= 3'd0;
            r_cnt   <= C_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request fields, captured only on acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op <= 3'b000;
            r_x  <= 3'b000;
            r_y  <= 3'b000;
        end else if (w_accept) begin
            r_op <= i_op;
            r_x  <= i_x;
            r_y  <= i_y;
        end else begin
            r_op <= r_op;
            r_x  <= r_x;
            r_y  <= r_y;
        end
    end

    // Registered outputs. Ready is high in IDLE and in DONE, so it returns
    // on the same cycle as the response pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn       <= 4'b0000;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_btn       <= w_btn_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
            r_rsp_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Result capture on the last SETTLE cycle. i_led comes from a register
    // on this clock, so it is sampled directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= 8'h00;
        end else if (w_capture) begin
            r_result <= ~i_led;
        end else begin
            r_result <= r_result;
        end
    end

    assign o_btn       = r_btn;
    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_result    = r_result;

endmodule

// File: tb/tb_calc_btn_driver.sv
// ---------------------------------------------------------------------------
// tb_calc_btn_driver
//
// Purpose:
//   Self-checking bench for calc_btn_driver with short pulse timing.
//   Accepting a request builds the expected per-cycle button trace and the
//   expected response into scoreboard queues. The trace comes from the
//   step list. Each cycle then pops the trace and compares it with the DUT.
//   Each response pulse pops and compares the response queue.
//   An LED model drives the result only during the settle window.
// ---------------------------------------------------------------------------
module tb_calc_btn_driver;

    localparam int HOLD   = 4;
    localparam int GAP    = 4;
    localparam int SETTLE = 3;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [2:0] i_op;
    logic [2:0] i_x;
    logic [2:0] i_y;
    logic [3:0] o_btn;
    logic [7:0] i_led;
    logic       o_rsp_valid;
    logic [7:0] o_result;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_btn_q[$];
    logic [7:0] exp_rsp_q[$];
    logic [7:0] prev_result;

    always #5 clk = ~clk;

    calc_btn_driver #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_op        (i_op),
        .i_x         (i_x),
        .i_y         (i_y),
        .o_btn       (o_btn),
        .i_led       (i_led),
        .o_rsp_valid (o_rsp_valid),
        .o_result    (o_result)
    );

    // Builds the expected o_btn value for cycles T+1 .. T+lat from the step list.
    task automatic build_expected(input logic [2:0] op, input logic [2:0] x,
                                  input logic [2:0] y, output int p, output int lat);
        logic [3:0] m[6];
        m[0] = {1'b0, op};
        m[1] = 4'b1000;
        m[2] = {1'b0, x};
        m[3] = 4'b1000;
        m[4] = {1'b0, y};
        m[5] = 4'b1000;
        exp_btn_q.delete();
        p = 0;
        for (int s = 0; s < 6; s++) begin
            if (m[s] != 4'b0000) begin
                p++;
                repeat (HOLD) exp_btn_q.push_back(m[s]);
                repeat (GAP)  exp_btn_q.push_back(4'b0000);
            end
        end
        repeat (SETTLE) exp_btn_q.push_back(4'b0000);
        repeat (HOLD)   exp_btn_q.push_back(4'b1000);
        repeat (GAP)    exp_btn_q.push_back(4'b0000);
        exp_btn_q.push_back(4'b0000);
        lat = exp_btn_q.size();
    endtask

    // Runs one request from acceptance to response.
    // If abort_at > 0, the run is abandoned with a reset at cycle T+abort_at.
    task automatic run_request(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                               input logic [7:0] res, input bit hold_valid, input int abort_at);
        int         w;
        int         p;
        int         lat;
        int         cap_cyc;
        logic [3:0] eb;
        logic [7:0] er;
        logic [7:0] eres;
        i_op        = op;
        i_x         = x;
        i_y         = y;
        i_req_valid = 1'b1;
        w = 0;
        while (o_req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (o_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_wait: o_req_ready=%b required 1 within 100 cycles", o_req_ready);
            i_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        build_expected(op, x, y, p, lat);
        exp_rsp_q.push_back(res);
        cap_cyc = p * (HOLD + GAP) + SETTLE;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble the request inputs while busy; the DUT must use its
                // registered copy and must not accept anything new.
                i_req_valid = hold_valid;
                i_op        = ~op;
                i_x         = ~x;
                i_y         = y ^ 3'b101;
                i_led       = ~(res ^ 8'h3C);
            end
            if (k == cap_cyc - SETTLE + 1) begin
                i_led = ~res;
            end
            if (k == cap_cyc + 1) begin
                i_led = ~(res ^ 8'hC3);
            end
            if (k == abort_at) begin
                i_rst_n = 1'b0;
                #1;
                n_cmp++;
                if (o_btn !== 4'b0000) begin
                    n_err++;
                    $display("FAIL abort_btn: o_btn=%b required 0000", o_btn);
                end
                n_cmp++;
                if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_result !== 8'h00) begin
                    n_err++;
                    $display("FAIL abort_outs: ready=%b rsp=%b result=%h required 1 0 00",
                             o_req_ready, o_rsp_valid, o_result);
                end
                exp_btn_q.delete();
                exp_rsp_q.delete();
                i_req_valid = 1'b0;
                prev_result = 8'h00;
                @(negedge clk);
                i_rst_n = 1'b1;
                for (int j = 0; j < 60; j++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (o_rsp_valid !== 1'b0 || o_btn !== 4'b0000 || o_req_ready !== 1'b1) begin
                        n_err++;
                        $display("FAIL post_abort: cyc=%0d rsp=%b btn=%b ready=%b required 0 0000 1",
                                 j, o_rsp_valid, o_btn, o_req_ready);
                    end
                end
                return;
            end
            eb = exp_btn_q.pop_front();
            n_cmp++;
            if (o_btn !== eb) begin
                n_err++;
                $display("FAIL btn: T+%0d o_btn=%b required %b", k, o_btn, eb);
            end
            n_cmp++;
            if (o_req_ready !== (k == lat)) begin
                n_err++;
                $display("FAIL ready: T+%0d o_req_ready=%b required %b", k, o_req_ready, (k == lat));
            end
            n_cmp++;
            if (o_rsp_valid !== (k == lat)) begin
                n_err++;
                $display("FAIL rsp_valid: T+%0d o_rsp_valid=%b required %b", k, o_rsp_valid, (k == lat));
            end
            eres = (k <= cap_cyc) ? prev_result : res;
            n_cmp++;
            if (o_result !== eres) begin
                n_err++;
                $display("FAIL result_hold: T+%0d o_result=%h required %h", k, o_result, eres);
            end
            if (o_rsp_valid === 1'b1 && exp_rsp_q.size() > 0) begin
                er = exp_rsp_q.pop_front();
                n_cmp++;
                if (o_result !== er) begin
                    n_err++;
                    $display("FAIL rsp_result: T+%0d o_result=%h required %h", k, o_result, er);
                end
            end
        end
        n_cmp++;
        if (exp_rsp_q.size() != 0) begin
            n_err++;
            $display("FAIL rsp_missing: %0d responses outstanding, required 0", exp_rsp_q.size());
            exp_rsp_q.delete();
        end
        prev_result = res;
    endtask

    task automatic test_reset();
        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_op        = 3'b000;
        i_x         = 3'b000;
        i_y         = 3'b000;
        i_led       = 8'hFF;
        prev_result = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (o_btn !== 4'b0000 || o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_result !== 8'h00) begin
            n_err++;
            $display("FAIL reset: btn=%b ready=%b rsp=%b result=%h required 0000 1 0 00",
                     o_btn, o_req_ready, o_rsp_valid, o_result);
        end
        i_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_request(3'b101, 3'b000, 3'b011, 8'h2A, 1'b0, 0);
    endtask

    task automatic test_all_zero();
        run_request(3'b000, 3'b000, 3'b000, 8'h5C, 1'b0, 0);
    endtask

    task automatic test_full_masks();
        run_request(3'b111, 3'b111, 3'b111, 8'hE1, 1'b0, 0);
        run_request(3'b000, 3'b101, 3'b000, 8'h17, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_request(3'b010, 3'b001, 3'b110, 8'h99, 1'b1, 0);
        run_request(3'b100, 3'b000, 3'b111, 8'h33, 1'b1, 0);
        run_request(3'b001, 3'b011, 3'b000, 8'hC6, 1'b0, 0);
    endtask

    task automatic test_reset_mid_sequence();
        run_request(3'b101, 3'b000, 3'b011, 8'h77, 1'b0, 26);
        run_request(3'b001, 3'b010, 3'b011, 8'hA5, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_full_masks();
        test_back_to_back();
        test_reset_mid_sequence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: ends the run if the sequence above never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
